regfile_write_arbiter: RTL and testbench

Shares the register file's single write port (RW/DA/D) between two write-back requesters: req0 (ALU result path) and req1 (load/memory return path). Round-robin arbitration with a valid/ready handshake per requester. Granted writes are registered and driven onto the register file write port one cycle later. Writes to x0 are suppressed, and a pipeline stall input blocks all grants.

---
 rtl/regfile_write_arbiter.sv | 94 +++++++++
 tb/tb_regfile_write_arbiter.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file write port between the ALU and load
// write-back paths; granted writes appear on RW/DA/D one cycle after acceptance.
module regfile_write_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              RW,
  output logic [ADDR_W-1:0] DA,
  output logic [DATA_W-1:0] D,
  output logic              grant_id,
  output logic              conflict
);

  logic              ptr_q, ptr_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] da_q, da_d;
  logic [DATA_W-1:0] d_q, d_d;
  logic              gid_q, gid_d;
  logic              conflict_q, conflict_d;

  logic              arb_en;
  logic              gnt0, gnt1;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  // ptr_q names the requester that wins when both are valid.
  always_comb begin
    arb_en = ~rst & ~stall;
    gnt0   = arb_en & req0_valid & (~req1_valid | ~ptr_q);
    gnt1   = arb_en & req1_valid & (~req0_valid | ptr_q);
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  always_comb begin
    sel_addr = gnt1 ? req1_addr : req0_addr;
    sel_data = gnt1 ? req1_data : req0_data;
  end

  always_comb begin
    ptr_d      = ptr_q;
    rw_d       = 1'b0;
    da_d       = da_q;
    d_d        = d_q;
    gid_d      = gid_q;
    conflict_d = req0_valid & req1_valid & ~stall & ~rst;
    if (gnt0 | gnt1) begin
      // Hand priority to whoever lost (or did not ask) this time.
      ptr_d = gnt0;
      // x0 is hardwired zero: accept the write but keep the port disabled.
      rw_d  = (sel_addr != '0);
      da_d  = sel_addr;
      d_d   = sel_data;
      gid_d = gnt1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= 1'b0;
      rw_q       <= 1'b0;
      da_q       <= '0;
      d_q        <= '0;
      gid_q      <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      rw_q       <= rw_d;
      da_q       <= da_d;
      d_q        <= d_d;
      gid_q      <= gid_d;
      conflict_q <= conflict_d;
    end
  end

  assign RW       = rw_q;
  assign DA       = da_q;
  assign D        = d_q;
  assign grant_id = gid_q;
  assign conflict = conflict_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized bench for regfile_write_arbiter against a transaction-level model that
// also tracks the architectural register file contents.
module tb_regfile_write_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NREG = 1 << AW;
  localparam int NCYC = 3000;

  logic          clk = 1'b0;
  logic          rst, stall;
  logic          v0, v1;
  logic [AW-1:0] a0, a1;
  logic [DW-1:0] d0, d1;
  logic          r0, r1, rw, gid, conf;
  logic [AW-1:0] da;
  logic [DW-1:0] dq;

  regfile_write_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .req0_valid (v0),
    .req0_addr  (a0),
    .req0_data  (d0),
    .req0_ready (r0),
    .req1_valid (v1),
    .req1_addr  (a1),
    .req1_data  (d1),
    .req1_ready (r1),
    .RW         (rw),
    .DA         (da),
    .D          (dq),
    .grant_id   (gid),
    .conflict   (conf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Register file as seen through the DUT write port, and as the model says it must be.
  logic [DW-1:0] dut_rf   [NREG];
  logic [DW-1:0] model_rf [NREG];

  always @(posedge clk) begin
    if (rw === 1'b1) dut_rf[da] <= dq;
  end

  // Model state: who was served last, and what the port must show after the next edge.
  int            last_served;
  bit            exp_known;
  logic          exp_rw, exp_gid, exp_conf;
  logic [AW-1:0] exp_da;
  logic [DW-1:0] exp_d;

  task automatic new_req(output logic v, output logic [AW-1:0] a, output logic [DW-1:0] d);
    v = 1'b1;
    a = AW'($urandom_range(0, 7));
    d = $urandom;
  endtask

  initial begin
    bit g0, g1, hold_both;
    int winner;
    for (int i = 0; i < NREG; i++) begin
      dut_rf[i]   = '0;
      model_rf[i] = '0;
    end
    last_served = 1;
    exp_known   = 1'b0;
    {exp_rw, exp_gid, exp_conf, exp_da, exp_d} = '0;
    rst = 1'b1; stall = 1'b0;
    v0 = 1'b1; a0 = AW'(2); d0 = 32'd25;
    v1 = 1'b1; a1 = AW'(3); d1 = 32'd35;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      if (exp_known) begin
        check_eq("RW", 64'(rw), 64'(exp_rw));
        check_eq("DA", 64'(da), 64'(exp_da));
        check_eq("D", 64'(dq), 64'(exp_d));
        check_eq("grant_id", 64'(gid), 64'(exp_gid));
        check_eq("conflict", 64'(conf), 64'(exp_conf));
      end

      // Round robin expressed as "the one not served most recently wins a tie".
      winner = -1;
      if (!rst && !stall) begin
        if (v0 && v1)  winner = (last_served == 0) ? 1 : 0;
        else if (v0)   winner = 0;
        else if (v1)   winner = 1;
      end
      g0 = (winner == 0);
      g1 = (winner == 1);
      check_eq("req0_ready", 64'(r0), 64'(g0));
      check_eq("req1_ready", 64'(r1), 64'(g1));

      exp_known = 1'b1;
      if (rst) begin
        {exp_rw, exp_gid, exp_conf, exp_da, exp_d} = '0;
        last_served = 1;
      end else begin
        exp_conf = v0 && v1 && !stall;
        exp_rw   = 1'b0;
        if (winner >= 0) begin
          last_served = winner;
          exp_gid = (winner == 1);
          exp_da  = (winner == 1) ? a1 : a0;
          exp_d   = (winner == 1) ? d1 : d0;
          exp_rw  = (exp_da != 0);
          if (exp_da != 0) model_rf[exp_da] = exp_d;
        end
      end

      @(posedge clk);
      #1;
      // Directed opening: reset with both valid, alternation, a 3-cycle stall, then random.
      hold_both = (cyc < 14);
      if (g0) begin
        if (hold_both || $urandom_range(0, 9) < 7) new_req(v0, a0, d0);
        else v0 = 1'b0;
      end else if (!v0 && $urandom_range(0, 1) == 1) begin
        new_req(v0, a0, d0);
      end
      if (g1) begin
        if (hold_both || $urandom_range(0, 9) < 7) new_req(v1, a1, d1);
        else v1 = 1'b0;
      end else if (!v1 && $urandom_range(0, 1) == 1) begin
        new_req(v1, a1, d1);
      end
      if (cyc < 1)        rst = 1'b1;
      else if (cyc < 14)  rst = 1'b0;
      else                rst = ($urandom_range(0, 99) < 3);
      if (cyc >= 8 && cyc < 11) stall = 1'b1;
      else if (cyc < 14)        stall = 1'b0;
      else                      stall = ($urandom_range(0, 9) < 2);
    end

    // Drain the pipeline, then compare architectural state.
    v0 = 1'b0; v1 = 1'b0; rst = 1'b0; stall = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NREG; i++) check_eq($sformatf("rf[%0d]", i), 64'(dut_rf[i]), 64'(model_rf[i]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
